mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_WIDTH, default 16, width of the address and data buses.
REQ-002 Parameter NUM_REQ, default 3, number of requester ports; port 0 is the routing-table updater, ports 1..2 are the packet handler and the sink-table manager.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, limit on how long one grant may be held; used only when ARB_TIMEOUT_EN is defined.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 nrst  input  1  reset, asynchronous and active-low.
REQ-006 req  input  NUM_REQ  per-port request; held high for the whole multi-cycle access sequence.
REQ-007 m_addr  input  NUM_REQ*WORD_WIDTH  per-port address; port i occupies slice [i*WORD_WIDTH +: WORD_WIDTH].
REQ-008 m_wr_en  input  NUM_REQ  per-port write enable.
REQ-009 m_wdata  input  NUM_REQ*WORD_WIDTH  per-port write data, sliced as m_addr.
REQ-010 gnt  output  NUM_REQ  one-hot grant; all zeros when no port owns memory.
REQ-011 rdata  output  WORD_WIDTH  memory read data, broadcast to all ports.
REQ-012 address  output  WORD_WIDTH  address to the shared memory.
REQ-013 wr_en  output  1  write enable to the shared memory.
REQ-014 data_out  output  WORD_WIDTH  write data to the shared memory.
REQ-015 data_in  input  WORD_WIDTH  read data from the shared memory.
REQ-016 busy  output  1  high while any grant is active.
REQ-017 timeout  output  1  sticky flag, set when a grant is revoked by the watchdog.

Function
REQ-018 The FSM SHALL have two states: IDLE and OWNED.
REQ-019 In IDLE, if any req bit is high, the FSM SHALL register a one-hot gnt for the first requesting port, searching upward from the priority pointer modulo NUM_REQ, and SHALL enter OWNED; grant latency is one clock from req seen.
REQ-020 In OWNED, the FSM SHALL hold gnt for as long as the owner's req bit stays high; other req bits SHALL have no effect.
REQ-021 When the owner's req bit is low at a clock edge, the FSM SHALL clear gnt, set the pointer to (owner+1) mod NUM_REQ, and return to IDLE; the mandatory IDLE cycle guarantees at least one dead cycle between owners.
REQ-022 address, data_out and wr_en SHALL be combinational muxes of the granted port's slices; with no grant, address and data_out are 0 and wr_en is 0.
REQ-023 A port's m_wr_en SHALL never reach wr_en unless that port's gnt bit is high.
REQ-024 rdata SHALL equal data_in combinationally; memory read timing is unchanged by the arbiter.
REQ-025 busy SHALL equal the OR of the gnt bits.
REQ-026 If a req bit drops and another rises in the same cycle, the new request SHALL be served through the normal IDLE arbitration on the following cycle.
REQ-027 A req pulse shorter than one clock that is not sampled high at an edge SHALL be ignored.

Reset
REQ-028 While nrst is low: gnt = 0, FSM = IDLE, pointer = 0, timeout = 0, watchdog counter = 0, wr_en = 0, and all mask bits cleared.
REQ-029 If reset is asserted mid-grant, the grant and wr_en SHALL drop immediately (asynchronously), and the grant SHALL NOT be restored after reset.

Configuration
REQ-030 Macro ARB_TIMEOUT_EN, when defined: an 8-bit counter counts cycles in OWNED. On reaching TIMEOUT_CYCLES, the arbiter revokes the grant, sets timeout, advances the pointer, and masks that port until its req goes low.
REQ-031 Macro ARB_TIMEOUT_EN, when undefined: no counter and no mask are built, timeout is tied to 0, and a grant may be held indefinitely.

Verification
REQ-032 Single request: req=001 -> gnt=001 one clock later; m_addr0=16'h68A appears on address the same cycle.
REQ-033 Round-robin: req=111 held, each owner releases after 4 cycles -> grant order 001, 010, 100, 001, with one all-zero gnt cycle between owners.
REQ-034 Write isolation: port 1 drives m_wr_en=1 while gnt=001 -> wr_en=0; once gnt=010, address=m_addr1 and data_out=m_wdata1.
REQ-035 Reset mid-op: nrst low during a port 0 grant -> gnt=000 and wr_en=0 without waiting for a clock edge; after release, req=011 -> gnt=001.
REQ-036 With ARB_TIMEOUT_EN: port 2 holds req for 300 cycles -> gnt revoked after 255 cycles, timeout=1, port 2 not re-granted until its req drops; a pending port 0 is granted next.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin owner arbiter for a shared single-port memory.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int WORD_WIDTH     = 16,
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clock,
  input  logic                          nrst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] m_addr,
  input  logic [NUM_REQ-1:0]            m_wr_en,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] m_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [WORD_WIDTH-1:0]         rdata,
  output logic [WORD_WIDTH-1:0]         address,
  output logic                          wr_en,
  output logic [WORD_WIDTH-1:0]         data_out,
  input  logic [WORD_WIDTH-1:0]         data_in,
  output logic                          busy,
  output logic                          timeout
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t state_q, state_d;

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      own_q, own_d;
  logic [PW-1:0]      nxt;
  logic [NUM_REQ-1:0] elig;
  logic               expire;

  logic          hi_ok, lo_ok;
  logic [PW-1:0] hi, lo, pick;

  assign nxt = (own_q == PW'(NUM_REQ - 1)) ? '0 : own_q + PW'(1);

  // Lowest eligible port at/above the pointer, else lowest overall.
  always_comb begin
    hi_ok = 1'b0;
    lo_ok = 1'b0;
    hi    = '0;
    lo    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        lo_ok = 1'b1;
        lo    = PW'(i);
        if (PW'(i) >= ptr_q) begin
          hi_ok = 1'b1;
          hi    = PW'(i);
        end
      end
    end
    pick = hi_ok ? hi : lo;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    unique case (state_q)
      IDLE: begin
        if (lo_ok) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            gnt_d[i] = (pick == PW'(i));
          end
          own_d   = pick;
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (!req[own_q] || expire) begin
          gnt_d   = '0;
          ptr_d   = nxt;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0]         cnt_q;
  logic [NUM_REQ-1:0] mask_q;
  logic               to_q;

  // Grant is held for exactly TIMEOUT_CYCLES cycles before revocation.
  assign expire = (state_q == OWNED) && req[own_q] && (cnt_q == TO_LAST);
  assign elig    = req & ~mask_q;
  assign timeout = to_q;

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      cnt_q  <= '0;
      mask_q <= '0;
      to_q   <= 1'b0;
    end else begin
      if (state_q == OWNED && state_d == OWNED) begin
        cnt_q <= cnt_q + 8'd1;
      end else begin
        cnt_q <= '0;
      end
      mask_q <= (mask_q & req) | (expire ? gnt_q : '0);
      if (expire) begin
        to_q <= 1'b1;
      end
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign expire  = 1'b0;
  assign elig    = req;
  assign timeout = 1'b0;
`endif

  // Only the granted slice can reach the memory port.
  always_comb begin
    address  = '0;
    data_out = '0;
    wr_en    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        address  = address  | m_addr[i*WORD_WIDTH +: WORD_WIDTH];
        data_out = data_out | m_wdata[i*WORD_WIDTH +: WORD_WIDTH];
        wr_en    = wr_en    | m_wr_en[i];
      end
    end
  end

  assign gnt   = gnt_q;
  assign busy  = |gnt_q;
  assign rdata = data_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, round-robin, reset and
// grant-hold sequences checked through an expectation queue.
module tb_mem_arbiter;

  localparam int W = 16;
  localparam int N = 3;

  logic           clock = 1'b0;
  logic           nrst;
  logic [N-1:0]   req;
  logic [N*W-1:0] m_addr;
  logic [N-1:0]   m_wr_en;
  logic [N*W-1:0] m_wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   rdata;
  logic [W-1:0]   address;
  logic           wr_en;
  logic [W-1:0]   data_out;
  logic [W-1:0]   data_in;
  logic           busy;
  logic           timeout;

  mem_arbiter #(
    .WORD_WIDTH(W),
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .clock(clock),
    .nrst(nrst),
    .req(req),
    .m_addr(m_addr),
    .m_wr_en(m_wr_en),
    .m_wdata(m_wdata),
    .gnt(gnt),
    .rdata(rdata),
    .address(address),
    .wr_en(wr_en),
    .data_out(data_out),
    .data_in(data_in),
    .busy(busy),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  localparam logic [W-1:0] A0 = 16'h068A;
  localparam logic [W-1:0] A1 = 16'h1111;
  localparam logic [W-1:0] A2 = 16'h2222;
  localparam logic [W-1:0] D0 = 16'hA000;
  localparam logic [W-1:0] D1 = 16'hB111;
  localparam logic [W-1:0] D2 = 16'hC222;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] we;
    logic [N-1:0] gnt;
    logic         wr;
  } vec_t;

  typedef struct {
    string        name;
    logic [N-1:0] gnt;
    logic         wr;
    logic         to;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[13];
  int   checks = 0;
  int   errors = 0;
  logic exp_to = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_addr(input logic [N-1:0] g);
    case (g)
      3'b001:  return A0;
      3'b010:  return A1;
      3'b100:  return A2;
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] exp_data(input logic [N-1:0] g);
    case (g)
      3'b001:  return D0;
      3'b010:  return D1;
      3'b100:  return D2;
      default: return '0;
    endcase
  endfunction

  // Drive inputs, queue the expectation, clock once, compare.
  task automatic cyc(input string nm, input logic [N-1:0] r,
                     input logic [N-1:0] we, input logic [N-1:0] eg,
                     input logic ew);
    exp_t e;
    req     = r;
    m_wr_en = we;
    sb.push_back('{nm, eg, ew, exp_to});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk({e.name, ".gnt"}, 32'(gnt), 32'(e.gnt));
    chk({e.name, ".busy"}, 32'(busy), 32'(|e.gnt));
    chk({e.name, ".addr"}, 32'(address), 32'(exp_addr(e.gnt)));
    chk({e.name, ".dout"}, 32'(data_out), 32'(exp_data(e.gnt)));
    chk({e.name, ".wr"}, 32'(wr_en), 32'(e.wr));
    chk({e.name, ".to"}, 32'(timeout), 32'(e.to));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [N-1:0] rr_order [4];

  initial begin
    tbl[0]  = '{3'b001, 3'b000, 3'b001, 1'b0};
    tbl[1]  = '{3'b001, 3'b001, 3'b001, 1'b1};
    tbl[2]  = '{3'b011, 3'b010, 3'b001, 1'b0};
    tbl[3]  = '{3'b010, 3'b010, 3'b000, 1'b0};
    tbl[4]  = '{3'b010, 3'b010, 3'b010, 1'b1};
    tbl[5]  = '{3'b000, 3'b000, 3'b000, 1'b0};
    tbl[6]  = '{3'b000, 3'b111, 3'b000, 1'b0};
    tbl[7]  = '{3'b101, 3'b100, 3'b100, 1'b1};
    tbl[8]  = '{3'b001, 3'b100, 3'b000, 1'b0};
    tbl[9]  = '{3'b001, 3'b000, 3'b001, 1'b0};
    tbl[10] = '{3'b000, 3'b000, 3'b000, 1'b0};
    tbl[11] = '{3'b101, 3'b001, 3'b100, 1'b0};
    tbl[12] = '{3'b000, 3'b000, 3'b000, 1'b0};
    rr_order[0] = 3'b001;
    rr_order[1] = 3'b010;
    rr_order[2] = 3'b100;
    rr_order[3] = 3'b001;

    nrst    = 1'b0;
    req     = '0;
    m_wr_en = '0;
    m_addr  = {A2, A1, A0};
    m_wdata = {D2, D1, D0};
    data_in = 16'h5A3C;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.gnt", 32'(gnt), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.wr", 32'(wr_en), 32'h0);
    chk("rst.addr", 32'(address), 32'h0);
    chk("rst.to", 32'(timeout), 32'h0);
    chk("rdata", 32'(rdata), 32'h5A3C);
    nrst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cyc($sformatf("vec%0d", i), tbl[i].req, tbl[i].we,
          tbl[i].gnt, tbl[i].wr);
    end

    data_in = 16'h0F0F;
    #1;
    chk("rdata2", 32'(rdata), 32'h0F0F);

    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        cyc($sformatf("rr%0d_%0d", k, c), 3'b111, 3'b000,
            rr_order[k], 1'b0);
      end
      if (k < 3) begin
        cyc($sformatf("rr%0d_gap", k), 3'b111 & ~rr_order[k],
            3'b000, 3'b000, 1'b0);
      end
    end

    m_wr_en = 3'b001;
    #1;
    chk("mid.wr", 32'(wr_en), 32'h1);
    #2;
    nrst = 1'b0;
    #1;
    chk("mid.gnt", 32'(gnt), 32'h0);
    chk("mid.wr0", 32'(wr_en), 32'h0);
    chk("mid.busy", 32'(busy), 32'h0);
    @(posedge clock);
    #1;
    chk("mid.hold", 32'(gnt), 32'h0);
    nrst = 1'b1;
    cyc("post_rst", 3'b011, 3'b000, 3'b001, 1'b0);
    cyc("post_rel", 3'b000, 3'b000, 3'b000, 1'b0);

`ifdef ARB_TIMEOUT_EN
    cyc("to_gnt", 3'b100, 3'b000, 3'b100, 1'b0);
    for (int i = 1; i < 255; i++) begin
      cyc($sformatf("to_hold%0d", i), 3'b101, 3'b000, 3'b100, 1'b0);
    end
    exp_to = 1'b1;
    cyc("to_revoke", 3'b101, 3'b000, 3'b000, 1'b0);
    cyc("to_p0", 3'b101, 3'b000, 3'b001, 1'b0);
    cyc("to_p0b", 3'b101, 3'b000, 3'b001, 1'b0);
    cyc("to_p0rel", 3'b100, 3'b000, 3'b000, 1'b0);
    cyc("to_mask", 3'b100, 3'b000, 3'b000, 1'b0);
    cyc("to_drop", 3'b000, 3'b000, 3'b000, 1'b0);
    cyc("to_regnt", 3'b100, 3'b000, 3'b100, 1'b0);
`else
    cyc("hold_gnt", 3'b100, 3'b000, 3'b100, 1'b0);
    for (int i = 1; i < 300; i++) begin
      cyc($sformatf("hold%0d", i), 3'b101, 3'b000, 3'b100, 1'b0);
    end
    cyc("hold_rel", 3'b001, 3'b000, 3'b000, 1'b0);
    cyc("hold_p0", 3'b001, 3'b000, 3'b001, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
